// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage signal bundle between the fetch unit (slave) and its environment (master)
interface fetch_unit_if #(parameter int PC_W = 8);
   logic            start;
   logic            stall;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] imem_addr;
   logic [8:0]      imem_data;
   logic [8:0]      instruction_out;
   logic            instr_valid;
   logic [PC_W-1:0] pc_out;
   logic            halted;
   logic [15:0]     dyn_count;
   modport master (
      output start, stall, branch_taken, branch_target, imem_data,
      input  imem_addr, instruction_out, instr_valid, pc_out, halted, dyn_count
   );
   modport slave (
      input  start, stall, branch_taken, branch_target, imem_data,
      output imem_addr, instruction_out, instr_valid, pc_out, halted, dyn_count
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch into IF/ID with redirect, stall and halt handling.
// FETCH_DYN_COUNT_EN adds a saturating count of issued instructions on dyn_count.
module fetch_unit #(
   parameter int              PC_W       = 8,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input logic         clk,
   input logic         reset,
   fetch_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_pc_out;
   logic [8:0]      r_instr;
   logic            r_valid;
   logic            r_halted;
   logic            w_is_halt;
   assign w_is_halt           = bus.imem_data[8:4] == 5'b11010;
   assign bus.imem_addr       = r_pc;
   assign bus.instruction_out = r_instr;
   assign bus.instr_valid     = r_valid;
   assign bus.pc_out          = r_pc_out;
   assign bus.halted          = r_halted;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_pc     <= START_ADDR;
         r_pc_out <= '0;
         r_instr  <= '0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_valid <= 1'b0;
               if (bus.start) begin
                  r_state <= RUN;
                  r_pc    <= START_ADDR;
               end
            end
            RUN: begin
               if (bus.branch_taken) begin
                  r_pc    <= bus.branch_target;
                  r_instr <= '0;
                  r_valid <= 1'b0;
               end else if (!bus.stall) begin
                  r_instr  <= bus.imem_data;
                  r_pc_out <= r_pc;
                  r_valid  <= 1'b1;
                  // a halt word is issued but the PC parks on it
                  if (w_is_halt) begin
                     r_state  <= HALTED;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc <= r_pc + 1'b1;
                  end
               end
            end
            HALTED: begin
               r_instr <= '0;
               r_valid <= 1'b0;
               if (bus.branch_taken) begin
                  r_state  <= RUN;
                  r_pc     <= bus.branch_target;
                  r_halted <= 1'b0;
               end else if (bus.start) begin
                  r_state  <= RUN;
                  r_pc     <= START_ADDR;
                  r_halted <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
`ifdef FETCH_DYN_COUNT_EN
   logic        w_issue;
   logic        w_restart;
   logic [15:0] r_dyn;
   assign w_issue   = r_state == RUN && !bus.branch_taken && !bus.stall;
   assign w_restart = bus.start && (r_state == IDLE || (r_state == HALTED && !bus.branch_taken));
   always_ff @(posedge clk) begin
      if (reset || w_restart) r_dyn <= '0;
      else if (w_issue && r_dyn != 16'hFFFF) r_dyn <= r_dyn + 1'b1;
   end
   assign bus.dyn_count = r_dyn;
`else
   assign bus.dyn_count = '0;
`endif
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 9-bit pipelined CPU. Drives the instruction-memory address from a program counter and latches the returned word into the IF/ID register that feeds the control unit's `instruction_in`. Accepts branch/jump redirects and stalls from downstream. Stops fetching once a `halt` opcode has been issued.

## Interface
Parameters:
- `PC_W`, 8: program-counter and instruction-memory address width.
- `START_ADDR`, 0: PC value loaded on reset and on `start`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; dominates every other input.
- `start`  in  1  pulse; begins fetching from `START_ADDR`.
- `stall`  in  1  holds PC and IF/ID contents.
- `branch_taken`  in  1  redirect request from the branch/jump resolution stage.
- `branch_target`  in  PC_W  redirect address, valid with `branch_taken`.
- `imem_addr`  out  PC_W  instruction-memory address; equals the PC register.
- `imem_data`  in  9  instruction word; combinational, same cycle as `imem_addr`.
- `instruction_out`  out  9  IF/ID instruction; drives the control unit.
- `instr_valid`  out  1  `instruction_out` is a real instruction (0 = bubble).
- `pc_out`  out  PC_W  address of `instruction_out`.
- `halted`  out  1  fetch stopped after issuing `halt`.
- `dyn_count`  out  16  dynamic issued-instruction count (see Configuration).

## Operation
- States: IDLE, RUN, HALTED. Reset enters IDLE.
- IDLE: no fetch, `instr_valid`=0. `start` moves to RUN with PC=`START_ADDR` and clears `dyn_count`.
- RUN, priority order per cycle:
  1. `branch_taken`: PC<=`branch_target`; IF/ID <= bubble (`instruction_out`=9'h000, `instr_valid`=0). Overrides `stall`.
  2. `stall`: PC, `instruction_out`, `instr_valid`, `pc_out` hold.
  3. Otherwise `instruction_out`<=`imem_data`, `pc_out`<=PC, `instr_valid`<=1, PC<=PC+1.
- Halt detect: in case 3, when `imem_data[8:4]`==5'b11010:
  - The halt word is issued normally (valid=1).
  - PC holds at the halt address (no increment).
  - Next state is HALTED.
- HALTED:
  - `halted`=1. Next cycle IF/ID becomes a bubble, then stays a bubble.
  - `branch_taken` (an older branch squashing a wrong-path halt): return to RUN, PC<=`branch_target`, IF/ID bubble, `halted`<=0.
  - `start`: return to RUN at `START_ADDR`, `dyn_count` cleared, `halted`<=0.
  - `branch_taken` has priority over `start`.
- `start` in RUN is ignored.
- PC arithmetic is modulo 2^PC_W: address 2^PC_W−1 increments to 0.
- `branch_target` is used verbatim, with no offset.

## Timing
- Reset values: PC=`START_ADDR`, `imem_addr`=`START_ADDR`, `instruction_out`=0, `instr_valid`=0, `pc_out`=0, `halted`=0, `dyn_count`=0, state IDLE.
- Fetch latency is 1 cycle: the word at `imem_addr` in cycle N appears on `instruction_out` in cycle N+1.
- `start` asserted in cycle N puts `START_ADDR` on `imem_addr` in N+1; the first valid instruction appears in N+2.
- Redirect:
  - `branch_taken` in cycle N puts `branch_target` on `imem_addr` in N+1, with a bubble on IF/ID in N+1.
  - The target instruction becomes valid in N+2, unless stalled.
- `halted` rises in the cycle after the halt word is latched, i.e. the same cycle `instruction_out` shows the halt with valid=1.
- `stall` and `branch_taken` are sampled only at the clock edge. There are no combinational paths from inputs to outputs except `imem_data`, which is registered only.
- `reset` mid-RUN or mid-HALTED returns to reset values on the next edge, regardless of other inputs.

## Configuration
- `FETCH_DYN_COUNT_EN` defined:
  - `dyn_count` increments by 1 on each edge where a valid instruction is latched into IF/ID (case 3, including the halt word).
  - It saturates at 16'hFFFF.
  - It holds on stall, bubble, IDLE and HALTED.
  - It clears on reset and on `start`.
- Not defined: `dyn_count` is tied to 16'h0000 and no counter register is synthesized.

## Test plan
- Sequential fetch: reset, `start`, imem holds incrementing non-halt words. Required: `instruction_out`/`pc_out` give (word0,0),(word1,1),(word2,2) on consecutive cycles from N+2, and `dyn_count`=3 after three valid issues.
- Branch: `branch_taken`=1 with `branch_target`=8'h40 while fetching address 5. Required: next cycle `imem_addr`=8'h40 and `instr_valid`=0; following cycle `pc_out`=8'h40 and `instr_valid`=1. Repeat with `stall`=1 asserted together with the branch; the redirect must still occur.
- Stall: hold `stall`=1 for 3 cycles mid-stream. Required: `instruction_out`, `pc_out` and `imem_addr` frozen, `dyn_count` unchanged; the stream resumes in order.
- Halt: place 9'b110100000 at address 3. Required:
  - Halt issued with `pc_out`=3 and `halted`=1 in the same cycle.
  - `imem_addr` stays 3 and `instr_valid`=0 thereafter.
  - `dyn_count`=4.
  - `branch_taken` to 8'h10 afterward restores RUN and `halted`=0.
- Wrap and reset: `START_ADDR`=8'hFE, fetch 3 words. Required: `pc_out` sequence FE, FF, 00. Then assert `reset` mid-stream: next edge `instr_valid`=0, `imem_addr`=FE, `dyn_count`=0, state IDLE (no fetch until `start`).
